// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, a starvation counter forces one auxiliary slot.
// Optional performance counters are compiled in with `define REGFILE_ARB_PERF_EN.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        wb_write_enable,
    input  logic [2:0]        wb_reg_enc,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              aux_req_valid,
    input  logic [2:0]        aux_req_enc,
    input  logic [DATA_W-1:0] aux_req_data,
    output logic              aux_req_ready,
    output logic              pipe_stall,
    output logic [1:0]        reg_file_write_enable,
    output logic [2:0]        reg_file_register_encoding,
    output logic [DATA_W-1:0] reg_file_writeback_data
`ifdef REGFILE_ARB_PERF_EN
    ,
    output logic [15:0]       perf_aux_wait_cycles,
    output logic [15:0]       perf_forced_grants
`endif
);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt, starve_cnt_inc;
    logic             wb_req;
    logic             grant_wb_p0, grant_aux_p0;

    always_comb begin
        wb_req         = |wb_write_enable;
        starve_cnt_inc = starve_cnt + 1'b1;
        state_nxt      = NORMAL;
        starve_cnt_nxt = '0;
        grant_wb_p0    = 1'b0;
        grant_aux_p0   = 1'b0;
        aux_req_ready  = 1'b0;
        case (state)
            NORMAL: begin
                aux_req_ready = !wb_req;
                if (wb_req) begin
                    grant_wb_p0 = 1'b1;
                    // Only a lost auxiliary cycle extends the streak; anything else breaks it.
                    if (aux_req_valid) begin
                        if (starve_cnt_inc == CNT_W'(STARVE_LIMIT))
                            state_nxt = FORCE;
                        else
                            starve_cnt_nxt = starve_cnt_inc;
                    end
                end else if (aux_req_valid) begin
                    grant_aux_p0 = 1'b1;
                end
            end
            FORCE: begin
                aux_req_ready = 1'b1;
                grant_aux_p0  = aux_req_valid;
            end
            default: ;
        endcase
    end

    // Stage p0 -> p1: arbitration result registered onto the register-file port
    always_ff @(posedge clk) begin
        if (resetn) begin
            state                      <= NORMAL;
            starve_cnt                 <= '0;
            pipe_stall                 <= 1'b0;
            reg_file_write_enable      <= 2'b00;
            reg_file_register_encoding <= 3'd0;
            reg_file_writeback_data    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            pipe_stall <= (state_nxt == FORCE);
            if (grant_wb_p0) begin
                reg_file_write_enable      <= wb_write_enable;
                reg_file_register_encoding <= wb_reg_enc;
                reg_file_writeback_data    <= wb_data;
            end else if (grant_aux_p0) begin
                reg_file_write_enable      <= 2'b01;
                reg_file_register_encoding <= aux_req_enc;
                reg_file_writeback_data    <= aux_req_data;
            end else begin
                reg_file_write_enable      <= 2'b00;
            end
        end
    end

`ifdef REGFILE_ARB_PERF_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (resetn) begin
            perf_aux_wait_cycles <= 16'd0;
            perf_forced_grants   <= 16'd0;
        end else begin
            if (aux_req_valid && !aux_req_ready)
                perf_aux_wait_cycles <= sat_inc16(perf_aux_wait_cycles);
            if (state == FORCE && aux_req_valid)
                perf_forced_grants <= sat_inc16(perf_forced_grants);
        end
    end
`endif

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the pipeline writeback stage (primary, normally never stalls);
  - an auxiliary long-latency requester (multiply/divide unit, debug loader), using a valid/ready handshake.
- The writeback stage has fixed priority.
- A starvation counter forces an auxiliary grant by stalling the pipeline for one cycle.
- Sits between the writeback stage and the register file; its registered outputs drive the register-file write port directly.

Parameters:
- STARVE_LIMIT, 4: consecutive lost auxiliary cycles before a forced grant. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  synchronous, active-high reset (1 = reset).
- wb_write_enable  in  2  writeback write enable; a nonzero value is a writeback request.
- wb_reg_enc  in  3  writeback destination register.
- wb_data  in  32  writeback data.
- aux_req_valid  in  1  auxiliary write request.
- aux_req_enc  in  3  auxiliary destination register.
- aux_req_data  in  32  auxiliary write data.
- aux_req_ready  out  1  combinational; the auxiliary transfer occurs when valid and ready are both 1.
- pipe_stall  out  1  registered; while 1, the pipeline holds the mem/wb register and the writeback request is not consumed.
- reg_file_write_enable  out  2  to register file.
- reg_file_register_encoding  out  3  to register file.
- reg_file_writeback_data  out  32  to register file.

Behaviour:
- Interface (decided): single clock clk; resetn is synchronous and active-high.
- Definitions:
  - wb_req = |wb_write_enable.
  - An auxiliary write always drives reg_file_write_enable = 2'b01.
- States:
  - NORMAL: aux_req_ready = !wb_req; pipe_stall = 0.
  - FORCE: aux_req_ready = 1; pipe_stall = 1.
- Reset (resetn = 1 at a clock edge):
  - state = NORMAL, counter = 0, pipe_stall = 0.
  - All three reg_file_* outputs = 0.
  - A reset during FORCE returns to NORMAL with no write issued.
- Output latency: all reg_file_* outputs are registered, one cycle after the grant cycle.
  - If no source is granted in a cycle, reg_file_write_enable = 0 next cycle; encoding and data hold their previous values.
- NORMAL with wb_req = 1:
  - Writeback is written (enable, encoding and data passed through).
  - If aux_req_valid = 1 it is a loss cycle: counter increments. If the incremented value equals STARVE_LIMIT, next state = FORCE and counter clears.
- NORMAL with wb_req = 0 and aux_req_valid = 1: the auxiliary request is granted and written; counter clears.
- NORMAL with aux_req_valid = 0: counter clears.
- FORCE, single cycle, always returns to NORMAL:
  - If aux_req_valid = 1, the auxiliary request is written.
  - The writeback request presented that cycle is ignored; the pipeline re-presents it, held by the stall.
  - If aux_req_valid has dropped, no write occurs.
  - Counter clears either way.
- Auxiliary protocol: valid, encoding and data must stay stable until the transfer completes. Valid does not depend on ready.
- Same-register collision:
  - Writeback wins; the auxiliary request stays pending.
  - Program order between the two sources is the issuing units' responsibility; the arbiter does not reorder or merge.
- Counter width: no wrap is reachable, because the counter clears on reaching STARVE_LIMIT.

Optional Feature:
- Macro: REGFILE_ARB_PERF_EN.
- Defined: adds outputs perf_aux_wait_cycles [15:0] and perf_forced_grants [15:0].
  - Both are saturating counters, cleared by reset.
  - perf_aux_wait_cycles increments every cycle with aux_req_valid = 1 and aux_req_ready = 0.
  - perf_forced_grants increments on each FORCE cycle that completes an auxiliary transfer.
  - Both saturate at 16'hFFFF.
- Not defined: those ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Writeback only: wb_write_enable = 01, enc = 3, data = 0xDEADBEEF, aux idle. Next cycle: register-file enable = 01, enc = 3, data = 0xDEADBEEF; pipe_stall stays 0.
- Aux only: aux valid, enc = 5, data = 0x12345678, wb idle. Same cycle aux_req_ready = 1; next cycle enable = 01, enc = 5, data = 0x12345678.
- Starvation with STARVE_LIMIT = 4: wb_req and aux valid held continuously.
  - Writeback writes for 4 cycles.
  - Cycle 5: pipe_stall = 1 and aux_req_ready = 1; aux data appears on the port in cycle 6.
  - Cycle 6: writeback resumes and pipe_stall = 0.
- Aux drops valid during FORCE: no write the following cycle; state returns to NORMAL; counter = 0.
- Reset asserted during FORCE: next cycle pipe_stall = 0, enable = 0, and no aux write occurs.
- With REGFILE_ARB_PERF_EN: rerun the starvation scenario. Expect perf_aux_wait_cycles = 4 and perf_forced_grants = 1.
  - Separately, preload perf_aux_wait_cycles to 0xFFFF via force, apply one more wait cycle, and check it holds at 0xFFFF.
